// File: rtl/crc12_check.sv
// CRC-12 (poly 0x80F) frame checker: accumulates 32-bit data words, compares against a trailing CRC word.
// Optional saturating error counter output err_count when CRC12_CHECK_ERR_CNT_EN is defined.
module crc12_check #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic [11:0]      res_crc,
    output logic [CNT_W-1:0] res_count
`ifdef CRC12_CHECK_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    localparam logic [11:0]      POLY    = 12'h80F;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      rcrc_q, rcrc_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rok_q, rok_d;
    logic [11:0]      crc_next;
    logic             accept;

    // Full 32-bit word folded into the CRC in one cycle, bit 31 first.
    function automatic logic [11:0] crc12_word(input logic [11:0] crc, input logic [31:0] data);
        logic [11:0] c;
        logic        fb;
        c = crc;
        for (int unsigned i = 0; i < 32; i++) begin
            fb = c[11] ^ data[5'(31 - i)];
            c  = {c[10:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    assign crc_next = crc12_word(crc_q, in_data);
    assign in_ready = !rst && (state_q != REPORT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        rcrc_d  = rcrc_q;
        rcnt_d  = rcnt_q;
        rok_d   = rok_q;
        case (state_q)
            // Running CRC/count are zero in IDLE, so an empty frame shares the ACCUM path.
            IDLE, ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        rcrc_d  = crc_q;
                        rcnt_d  = cnt_q;
                        rok_d   = (crc_q == in_data[11:0]);
                        crc_d   = '0;
                        cnt_d   = '0;
                        state_d = REPORT;
                    end else begin
                        crc_d   = crc_next;
                        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            REPORT: begin
                if (res_ready) begin
                    rcrc_d  = '0;
                    rcnt_d  = '0;
                    rok_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= '0;
            cnt_q   <= '0;
            rcrc_q  <= '0;
            rcnt_q  <= '0;
            rok_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            rcrc_q  <= rcrc_d;
            rcnt_q  <= rcnt_d;
            rok_q   <= rok_d;
        end
    end

    // Result registers are cleared on handshake, so they already read zero outside REPORT.
    assign res_valid = (state_q == REPORT);
    assign res_ok    = rok_q;
    assign res_crc   = rcrc_q;
    assign res_count = rcnt_q;

`ifdef CRC12_CHECK_ERR_CNT_EN
    logic [CNT_W-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == REPORT) && res_ready && !rok_q && (err_q != CNT_MAX)) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_crc12_check.sv
// Self-checking bench for crc12_check: directed frames plus randomized traffic against a frame-level model.
// Define CRC12_CHECK_ERR_CNT_EN to also check err_count.
module tb_crc12_check;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          res_valid;
    logic          res_ready;
    logic          res_ok;
    logic [11:0]   res_crc;
    logic [CW-1:0] res_count;
`ifdef CRC12_CHECK_ERR_CNT_EN
    logic [CW-1:0] err_count;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    crc12_check #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .res_crc   (res_crc),
        .res_count (res_count)
`ifdef CRC12_CHECK_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC as remainder of M(x)*x^12 divided by P(x), message = all word bits MSB first.
    function automatic logic [11:0] crc_of(input logic [31:0] w[$]);
        logic [12:0] rem;
        logic        b;
        rem = '0;
        for (int k = 0; k < w.size() * 32 + 12; k++) begin
            if (k < w.size() * 32) b = w[k / 32][31 - (k % 32)];
            else                   b = 1'b0;
            rem = {rem[11:0], b};
            if (rem[12]) rem = rem ^ 13'h180F;
        end
        return rem[11:0];
    endfunction

    // Frame-level model.
    logic [31:0] mq[$];
    bit          started = 0;
    bit          pend = 0;
    bit          m_ok = 0;
    logic [11:0] m_crc = '0;
    int unsigned m_cnt = 0;
    int unsigned m_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            pend    = 0;
            m_ok    = 0;
            m_crc   = '0;
            m_cnt   = 0;
            m_err   = 0;
            mq.delete();
        end else if (started) begin
            if (pend) begin
                if (res_ready) begin
                    if (!m_ok && m_err != MAX) m_err++;
                    pend  = 0;
                    m_ok  = 0;
                    m_crc = '0;
                    m_cnt = 0;
                end
            end else if (in_valid) begin
                if (in_last) begin
                    m_crc = crc_of(mq);
                    m_cnt = (mq.size() > MAX) ? MAX : mq.size();
                    m_ok  = (m_crc == in_data[11:0]);
                    pend  = 1;
                    mq.delete();
                end else begin
                    mq.push_back(in_data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",  in_ready,  (!rst && !pend) ? 1 : 0);
            chk("res_valid", res_valid, pend ? 1 : 0);
            chk("res_ok",    res_ok,    m_ok ? 1 : 0);
            chk("res_crc",   res_crc,   m_crc);
            chk("res_count", res_count, m_cnt);
`ifdef CRC12_CHECK_ERR_CNT_EN
            chk("err_count", err_count, m_err);
`endif
        end
    end

    task automatic send(input logic [31:0] d, input logic last);
        bit r;
        bit done = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) done = 1;
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res();
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (res_valid) got = 1;
        end
        if (!got) chk("res_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] sq[$];
        int unsigned e0;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_crc", res_crc, 0);
            chk("rst_res_count", res_count, 0);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Basic good frame, result the cycle after the CRC word.
        send(32'h0000_0001, 1'b0);
        send(32'h0000_080F, 1'b1);
        @(negedge clk);
        chk("f1_valid", res_valid, 1);
        chk("f1_ok", res_ok, 1);
        chk("f1_crc", res_crc, 12'h80F);
        chk("f1_count", res_count, 1);
        @(posedge clk); #1;

        // Bad CRC; upper bits of the CRC word ignored but low bits mismatch.
`ifdef CRC12_CHECK_ERR_CNT_EN
        e0 = err_count;
`else
        e0 = 0;
`endif
        send(32'h0000_0001, 1'b0);
        send(32'hFFFF_F800, 1'b1);
        @(negedge clk);
        chk("f2_ok", res_ok, 0);
        chk("f2_crc", res_crc, 12'h80F);
        @(posedge clk); #1;
        @(negedge clk);
`ifdef CRC12_CHECK_ERR_CNT_EN
        chk("f2_err_count", err_count, e0 + 1);
`endif
        @(posedge clk); #1;

        // Zero words with gaps; then a lone CRC word.
        for (int i = 0; i < 3; i++) begin
            send(32'h0, 1'b0);
            repeat (2) @(posedge clk);
            #1;
        end
        send(32'h0, 1'b1);
        @(negedge clk);
        chk("f3_ok", res_ok, 1);
        chk("f3_crc", res_crc, 0);
        chk("f3_count", res_count, 3);
        @(posedge clk); #1;
        send(32'h0, 1'b1);
        @(negedge clk);
        chk("f4_ok", res_ok, 1);
        chk("f4_count", res_count, 0);
        @(posedge clk); #1;

        // Backpressure with a word offered while the result is pending.
        res_ready = 1'b0;
        send(32'h0000_0001, 1'b0);
        send(32'h0000_080F, 1'b1);
        in_data = 32'h0000_0002; in_last = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_crc", res_crc, 12'h80F);
            chk("bp_in_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_in_ready", in_ready, 1);
        chk("bp_after_valid", res_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        send(32'h0000_0811, 1'b1);
        @(negedge clk);
        chk("bp_next_ok", res_ok, 1);
        chk("bp_next_count", res_count, 1);
        @(posedge clk); #1;

        // Reset mid-frame discards it.
        send(32'h0000_AAAA, 1'b0);
        send(32'h0000_1234, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_after_ready", in_ready, 1);
        chk("midrst_no_result", res_valid, 0);
        @(posedge clk); #1;
        send(32'h0000_0002, 1'b0);
        send(32'h0000_0811, 1'b1);
        @(negedge clk);
        chk("f5_ok", res_ok, 1);
        chk("f5_count", res_count, 1);
        @(posedge clk); #1;

        // Reset while a result is pending.
        res_ready = 1'b0;
        send(32'h0000_0003, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        chk("rptrst_no_result", res_valid, 0);
        @(posedge clk); #1;

        // Count saturation: CRC keeps accumulating past the count limit.
        sq.delete();
        for (int i = 0; i < MAX + 5; i++) begin
            sq.push_back($urandom);
            send(sq[i], 1'b0);
        end
        send({20'h0, crc_of(sq)}, 1'b1);
        wait_res();
        chk("sat_count", res_count, MAX);
        chk("sat_ok", res_ok, 1);
        @(posedge clk); #1;

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_last   = ($urandom_range(0, 5) == 0);
            res_ready = ($urandom_range(0, 3) != 0);
            if (in_last && $urandom_range(0, 1) == 1) in_data = {20'($urandom), crc_of(mq)};
            else                                      in_data = $urandom;
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crc12_check.md
CRC12_CHECK -- requirements
Module: crc12_check

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the frame word counter and error counter.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  32  data word, or received-CRC word when in_last=1.
REQ-005 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-006 SHALL have port in_last  input  1  current word is the frame's CRC word; received CRC is in_data[11:0].
REQ-007 SHALL have port in_ready  output  1  block accepts a word; transfer occurs when in_valid&in_ready.
REQ-008 SHALL have port res_valid  output  1  frame result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_ok  output  1  computed CRC equals received CRC.
REQ-011 SHALL have port res_crc  output  12  CRC computed over the frame's data words.
REQ-012 SHALL have port res_count  output  CNT_W  number of data words in the frame, excluding the CRC word.

Function
REQ-013 SHALL compute CRC-12: polynomial 0x80F (x^12+x^11+x^3+x^2+x+1), init 0x000, no reflection, no final XOR.
REQ-014 SHALL process each accepted data word fully in one cycle, MSB first (bit 31 first), words in arrival order.
REQ-015 SHALL implement states IDLE, ACCUM, REPORT; reset state IDLE.
REQ-016 IDLE: data word accepted -> ACCUM; CRC word (in_last=1) accepted -> REPORT with empty frame (res_crc 0x000, res_count 0).
REQ-017 ACCUM: data word accepted -> stay; CRC word accepted -> REPORT.
REQ-018 REPORT: res_valid=1, outputs stable; res_valid&res_ready -> IDLE with running CRC 0x000 and count 0.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, 0 in REPORT; no input is accepted while a result is pending.
REQ-020 Latency: CRC word accepted in cycle N -> res_valid=1 in cycle N+1.
REQ-021 res_ok SHALL compare res_crc with in_data[11:0] of the CRC word; in_data[31:12] of the CRC word is ignored.
REQ-022 Cycles with in_valid=0 SHALL leave the CRC, count and state unchanged.
REQ-023 res_count SHALL saturate at 2^CNT_W-1; the CRC continues to accumulate after saturation.
REQ-024 res_ok, res_crc and res_count SHALL be 0 whenever res_valid=0.

Reset
REQ-025 rst=1 SHALL, at the next clock edge, force IDLE, running CRC 0x000, count 0, in_ready=0 during reset, and res_valid/res_ok/res_crc/res_count=0.
REQ-026 rst asserted mid-frame or during REPORT SHALL discard the frame/result with no result emitted; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-027 With macro CRC12_CHECK_ERR_CNT_EN defined, SHALL add output err_count (CNT_W, output): increments by 1 on each result handshake with res_ok=0, saturates at 2^CNT_W-1, reset to 0 only by rst.
REQ-028 Without CRC12_CHECK_ERR_CNT_EN, port err_count and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset: hold rst 2 cycles -> res_valid=0, res_ok=0, res_crc=0x000, res_count=0, in_ready=0 during rst, 1 after.
REQ-030 Frame {0x00000001, CRC word 0x0000080F(last)}, res_ready=1 -> next cycle res_valid=1, res_ok=1, res_crc=0x80F, res_count=1.
REQ-031 Frame {0x00000001, CRC word 0xFFFFF800(last)} -> res_ok=0, res_crc=0x80F; with macro err_count 0->1 after handshake.
REQ-032 Frame {0x0,0x0,0x0, CRC word 0x00000000(last)} with in_valid gaps of 2 cycles between words -> res_ok=1, res_crc=0x000, res_count=3; lone CRC word 0x0 -> res_ok=1, res_count=0.
REQ-033 Backpressure: res_ready=0 for 5 cycles after result -> res_valid and outputs held, in_ready=0, offered words not accepted; next frame accepted the cycle after handshake.
REQ-034 rst pulsed after two data words of a frame -> no result; subsequent frame {0x00000002, CRC word 0x00000811} -> res_ok=1, res_count=1.
